// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: widths, ALU op codes,
// FSM state encodings and the forwarding-match helper.
package alu_issue_seq_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int OPW  = 4;

   typedef enum logic [OPW-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_e;

   // x0 is never a forwarding source: it always reads as zero.
   function automatic logic fwd_hit(input logic [AW-1:0] src, input logic [AW-1:0] dst);
      return (src == dst) && (src != '0);
   endfunction

endpackage

// File: rtl/alu_issue_seq_regfile.sv
// Register file for the issue sequencer: two operand read ports, one debug read port,
// one write port, asynchronous clear, x0 hardwired to zero.
module alu_regfile
   import alu_issue_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   output logic [XLEN-1:0] rdata1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata2,
   input  logic [AW-1:0]   dbg_idx,
   output logic [XLEN-1:0] dbg_data
);

   logic [XLEN-1:0] mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1   = (raddr1  == '0) ? '0 : mem[raddr1];
   assign rdata2   = (raddr2  == '0) ? '0 : mem[raddr2];
   assign dbg_data = (dbg_idx == '0) ? '0 : mem[dbg_idx];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer: reads operands for a request, holds them on the ALU inputs
// for one cycle, captures the result and writes it back, with WB-to-issue forwarding.
module alu_issue_seq
   import alu_issue_seq_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [OPW-1:0]  req_op,
   input  logic [AW-1:0]   req_rs1,
   input  logic [AW-1:0]   req_rs2,
   input  logic [AW-1:0]   req_rd,
   input  logic            ld_valid,
   input  logic [AW-1:0]   ld_idx,
   input  logic [XLEN-1:0] ld_data,
   output logic [OPW-1:0]  alu_op,
   output logic [XLEN-1:0] alu_rs1,
   output logic [XLEN-1:0] alu_rs2,
   input  logic [XLEN-1:0] alu_rd,
   output logic            wb_valid,
   output logic [AW-1:0]   wb_idx,
   output logic [XLEN-1:0] wb_data,
   input  logic [AW-1:0]   dbg_idx,
   output logic [XLEN-1:0] dbg_data
);

   state_e          state, state_nxt;
   logic [AW-1:0]   rd_p1;
   logic            hs;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [XLEN-1:0] rf_rdata1, rf_rdata2;
   logic [XLEN-1:0] op1, op2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = !ld_valid;
            if (req_valid && !ld_valid) state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_WB;
         ST_WB: begin
            req_ready = 1'b1;
            state_nxt = req_valid ? ST_EXEC : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign hs       = req_valid && req_ready;
   assign wb_valid = (state == ST_WB);

   // The WB write and a new issue share an edge, so the file still holds the old value.
   assign op1 = ((state == ST_WB) && fwd_hit(req_rs1, wb_idx)) ? wb_data : rf_rdata1;
   assign op2 = ((state == ST_WB) && fwd_hit(req_rs2, wb_idx)) ? wb_data : rf_rdata2;

   assign rf_we    = (state == ST_WB) || ((state == ST_IDLE) && ld_valid);
   assign rf_waddr = (state == ST_WB) ? wb_idx  : ld_idx;
   assign rf_wdata = (state == ST_WB) ? wb_data : ld_data;

   // Issue stage: operands and op registered onto the ALU inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op  <= '0;
         alu_rs1 <= '0;
         alu_rs2 <= '0;
         rd_p1   <= '0;
      end else if (hs) begin
         alu_op  <= req_op;
         alu_rs1 <= op1;
         alu_rs2 <= op2;
         rd_p1   <= req_rd;
      end
   end

   // Writeback stage: ALU result captured after its full EXEC cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_idx  <= '0;
         wb_data <= '0;
      end else if (state == ST_EXEC) begin
         wb_idx  <= rd_p1;
         wb_data <= alu_rd;
      end
   end

   alu_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .raddr1   (req_rs1),
      .rdata1   (rf_rdata1),
      .raddr2   (req_rs2),
      .rdata2   (rf_rdata2),
      .dbg_idx  (dbg_idx),
      .dbg_data (dbg_data)
   );

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq with an unsigned less-than ALU on the operand bus: directed
// table vectors, hand-written corner sequences and a randomized run against a model.
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [4:0]  req_rs1, req_rs2, req_rd;
   logic        ld_valid;
   logic [4:0]  ld_idx;
   logic [31:0] ld_data;
   logic [3:0]  alu_op;
   logic [31:0] alu_rs1, alu_rs2, alu_rd;
   logic        wb_valid;
   logic [4:0]  wb_idx;
   logic [31:0] wb_data;
   logic [4:0]  dbg_idx;
   logic [31:0] dbg_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign alu_rd = (alu_rs1 < alu_rs2) ? 32'd1 : 32'd0;

   alu_issue_seq dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
      .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
      .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
      .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
      .dbg_idx(dbg_idx), .dbg_data(dbg_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [4:0] idx, input logic [31:0] data);
      @(negedge clk);
      ld_valid = 1'b1; ld_idx = idx; ld_data = data;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic drive_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      req_valid = 1'b1; req_op = 4'd3; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
   endtask

   task automatic check_dbg(input string name, input logic [4:0] idx, input logic [31:0] exp);
      dbg_idx = idx;
      #1;
      check(name, dbg_data, exp);
   endtask

   typedef struct {
      bit          do_ld;
      logic [4:0]  ld1_idx;
      logic [31:0] ld1_data;
      logic [4:0]  ld2_idx;
      logic [31:0] ld2_data;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] exp_a, exp_b, exp_res, exp_reg;
   } vec_t;

   vec_t vecs [4];

   logic [31:0] m [32];
   int          phase;
   logic [31:0] ea, eb, er;
   logic [4:0]  erd;
   logic [3:0]  eop;
   logic        exp_ready, hs;

   function automatic logic [31:0] rand_data();
      case ($urandom_range(3))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return $urandom;
         default: return 32'($urandom_range(3));
      endcase
   endfunction

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      ld_valid = 1'b0; ld_idx = '0; ld_data = '0; dbg_idx = '0;

      vecs[0] = '{1'b1, 5'd1, 32'd2, 5'd2, 32'd1,          5'd1, 5'd2, 5'd3, 32'd2, 32'd1,          32'd0, 32'd0};
      vecs[1] = '{1'b1, 5'd1, 32'd1, 5'd2, 32'hFFFF_FFFF,  5'd1, 5'd2, 5'd3, 32'd1, 32'hFFFF_FFFF,  32'd1, 32'd1};
      vecs[2] = '{1'b0, 5'd0, 32'd0, 5'd0, 32'd0,          5'd2, 5'd1, 5'd3, 32'hFFFF_FFFF, 32'd1,  32'd0, 32'd0};
      vecs[3] = '{1'b0, 5'd0, 32'd0, 5'd0, 32'd0,          5'd1, 5'd2, 5'd0, 32'd1, 32'hFFFF_FFFF,  32'd1, 32'd0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_wb_valid", 32'(wb_valid), 32'd0);
      check("reset_alu_rs1", alu_rs1, 32'd0);
      for (int i = 0; i < 32; i++) begin
         check_dbg($sformatf("reset_dbg_x%0d", i), 5'(i), 32'd0);
      end

      // Table-driven single requests
      for (int v = 0; v < 4; v++) begin
         if (vecs[v].do_ld) begin
            do_load(vecs[v].ld1_idx, vecs[v].ld1_data);
            do_load(vecs[v].ld2_idx, vecs[v].ld2_data);
         end
         @(negedge clk);
         drive_req(vecs[v].rs1, vecs[v].rs2, vecs[v].rd);
         #1;
         check($sformatf("v%0d_ready", v), 32'(req_ready), 32'd1);
         @(negedge clk);
         req_valid = 1'b0;
         check($sformatf("v%0d_exec_rs1", v), alu_rs1, vecs[v].exp_a);
         check($sformatf("v%0d_exec_rs2", v), alu_rs2, vecs[v].exp_b);
         check($sformatf("v%0d_exec_wbv", v), 32'(wb_valid), 32'd0);
         @(negedge clk);
         check($sformatf("v%0d_wbv", v), 32'(wb_valid), 32'd1);
         check($sformatf("v%0d_wb_idx", v), 32'(wb_idx), 32'(vecs[v].rd));
         check($sformatf("v%0d_wb_data", v), wb_data, vecs[v].exp_res);
         @(negedge clk);
         check_dbg($sformatf("v%0d_dbg", v), vecs[v].rd, vecs[v].exp_reg);
      end

      // Forwarding from WB into a back-to-back issue
      do_load(5'd1, 32'd2);
      do_load(5'd2, 32'd5);
      @(negedge clk);
      drive_req(5'd1, 5'd2, 5'd3);
      @(negedge clk);
      req_valid = 1'b0;
      check("fwdA_rs1", alu_rs1, 32'd2);
      check("fwdA_rs2", alu_rs2, 32'd5);
      @(negedge clk);
      check("fwdA_wbv", 32'(wb_valid), 32'd1);
      check("fwdA_wb_data", wb_data, 32'd1);
      drive_req(5'd3, 5'd1, 5'd4);
      #1;
      check("fwdB_ready_in_wb", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("fwdB_gap_wbv", 32'(wb_valid), 32'd0);
      check("fwdB_rs1_forwarded", alu_rs1, 32'd1);
      check("fwdB_rs2", alu_rs2, 32'd2);
      @(negedge clk);
      check("fwdB_wbv", 32'(wb_valid), 32'd1);
      check("fwdB_wb_idx", 32'(wb_idx), 32'd4);
      check("fwdB_wb_data", wb_data, 32'd1);
      @(negedge clk);
      check_dbg("fwd_dbg_x3", 5'd3, 32'd1);
      check_dbg("fwd_dbg_x4", 5'd4, 32'd1);

      // rd=x0 followed by an rs1=x0 issue in WB: no forwarding from x0
      @(negedge clk);
      drive_req(5'd1, 5'd2, 5'd0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("x0_wbv", 32'(wb_valid), 32'd1);
      check("x0_wb_idx", 32'(wb_idx), 32'd0);
      check("x0_wb_data", wb_data, 32'd1);
      drive_req(5'd0, 5'd1, 5'd6);
      @(negedge clk);
      req_valid = 1'b0;
      check("x0_nofwd_rs1", alu_rs1, 32'd0);
      check("x0_rs2", alu_rs2, 32'd2);
      @(negedge clk);
      check("x0_follow_wb_data", wb_data, 32'd1);
      @(negedge clk);
      check_dbg("x0_dbg_x0", 5'd0, 32'd0);
      check_dbg("x0_dbg_x6", 5'd6, 32'd1);

      // Load and request together in IDLE: load wins, request reads the new value
      @(negedge clk);
      ld_valid = 1'b1; ld_idx = 5'd7; ld_data = 32'd5;
      drive_req(5'd7, 5'd1, 5'd8);
      #1;
      check("coll_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
      check("coll_ready_next", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("coll_rs1_new", alu_rs1, 32'd5);
      check("coll_rs2", alu_rs2, 32'd2);
      ld_valid = 1'b1; ld_idx = 5'd9; ld_data = 32'd77;
      @(negedge clk);
      ld_valid = 1'b0;
      check("coll_wb_idx", 32'(wb_idx), 32'd8);
      check("coll_wb_data", wb_data, 32'd0);
      @(negedge clk);
      check_dbg("ld_ignored_busy", 5'd9, 32'd0);

      // Reset asserted during EXEC aborts the operation
      @(negedge clk);
      drive_req(5'd1, 5'd2, 5'd10);
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_mid_exec_rs1", alu_rs1, 32'd2);
      rst = 1'b1;
      #1;
      check("rst_mid_wbv", 32'(wb_valid), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_alu_rs1", alu_rs1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_no_wb", 32'(wb_valid), 32'd0);
      end
      check_dbg("rst_mid_x10", 5'd10, 32'd0);
      check_dbg("rst_mid_x1", 5'd1, 32'd0);

      // Randomized run: model applies each request in program order at issue time
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      phase = 0; ea = '0; eb = '0; er = '0; erd = '0; eop = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (phase == 1) begin
            check("rnd_alu_rs1", alu_rs1, ea);
            check("rnd_alu_rs2", alu_rs2, eb);
            check("rnd_alu_op", 32'(alu_op), 32'(eop));
            check("rnd_exec_wbv", 32'(wb_valid), 32'd0);
         end else if (phase == 2) begin
            check("rnd_wbv", 32'(wb_valid), 32'd1);
            check("rnd_wb_idx", 32'(wb_idx), 32'(erd));
            check("rnd_wb_data", wb_data, er);
         end else begin
            check("rnd_idle_wbv", 32'(wb_valid), 32'd0);
         end
         if (cyc < 2990) begin
            req_valid = 1'($urandom_range(1));
            ld_valid  = ($urandom_range(3) == 0);
         end else begin
            req_valid = 1'b0;
            ld_valid  = 1'b0;
         end
         req_op  = 4'($urandom_range(15));
         req_rs1 = 5'($urandom_range(7));
         req_rs2 = 5'($urandom_range(7));
         req_rd  = 5'($urandom_range(7));
         ld_idx  = 5'($urandom_range(7));
         ld_data = rand_data();
         #1;
         exp_ready = ((phase == 0) && !ld_valid) || (phase == 2);
         check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
         hs = req_valid && exp_ready;
         if ((phase == 0) && ld_valid && (ld_idx != 0)) m[ld_idx] = ld_data;
         if (hs) begin
            ea  = m[req_rs1];
            eb  = m[req_rs2];
            er  = (ea < eb) ? 32'd1 : 32'd0;
            erd = req_rd;
            eop = req_op;
            if (req_rd != 0) m[req_rd] = er;
            phase = 1;
         end else begin
            phase = (phase == 1) ? 2 : 0;
         end
      end
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         check_dbg($sformatf("rnd_final_x%0d", i), 5'(i), m[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
